// File: rtl/axi4_mem_arbiter.sv
// Two-requester arbiter in front of a single AXI-style memory slave.
// One transaction is in flight at a time. Requesters are served round-robin
// when both ask together. A watchdog aborts any slave handshake that stalls
// for TIMEOUT cycles and reports it as an error response.
module axi4_mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [1:0]  REQ_VALID,
   input  logic [1:0]  REQ_WRITE,
   input  logic [9:0]  REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic [1:0]  REQ_READY,
   output logic [1:0]  RSP_VALID,
   output logic [15:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [4:0]  M_A_W_ADDR,
   output logic        M_A_W_VALID,
   input  logic        M_A_W_READY,
   output logic [15:0] M_W_DATA,
   output logic        M_W_VALID,
   input  logic        M_W_READY,
   input  logic        M_B_VALID,
   input  logic [1:0]  M_B_RESP,
   output logic        M_B_READY,
   output logic [4:0]  M_A_R_ADDR,
   output logic        M_A_R_VALID,
   input  logic        M_A_R_READY,
   input  logic [15:0] M_R_DATA,
   input  logic        M_R_VALID,
   output logic        M_R_READY
);

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

   // Watchdog fires on the TIMEOUT-th stalled cycle of a handshake state.
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

   state_t      state;
   logic        last;      // index of the requester granted most recently
   logic        gnt;       // index of the requester that owns the transaction
   logic [4:0]  addr_l;
   logic [15:0] data_l;
   logic [7:0]  wdog;

   logic        win;
   logic        hs;
   logic        in_wait;
   logic        wd_hit;
   logic [1:0]  gnt_oh;
   logic [4:0]  win_addr;
   logic [15:0] win_data;
   logic        win_write;

   // Address and data channels simply present the latched request; the
   // VALID bits say when they mean anything.
   assign M_A_W_ADDR = addr_l;
   assign M_A_R_ADDR = addr_l;
   assign M_W_DATA   = data_l;

   assign gnt_oh    = gnt ? 2'b10 : 2'b01;
   assign win_addr  = win ? REQ_ADDR[9:5] : REQ_ADDR[4:0];
   assign win_data  = win ? REQ_WDATA[31:16] : REQ_WDATA[15:0];
   assign win_write = win ? REQ_WRITE[1] : REQ_WRITE[0];
   assign in_wait   = (state == AW) || (state == W) || (state == B) ||
                      (state == AR) || (state == R);
   assign wd_hit    = (wdog == WD_LIMIT);

   // Arbitration: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      win = (REQ_VALID == 2'b11) ? ~last : REQ_VALID[1];
   end

   // Handshake completion condition of the current slave-facing state.
   always_comb begin
      hs = 1'b0;
      case (state)
         AW:      hs = M_A_W_READY;
         W:       hs = M_W_READY;
         B:       hs = M_B_VALID;
         AR:      hs = M_A_R_READY;
         R:       hs = M_R_VALID;
         default: hs = 1'b0;
      endcase
   end

   // Transaction FSM with registered outputs and the handshake watchdog.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         last        <= 1'b1;
         gnt         <= 1'b0;
         addr_l      <= '0;
         data_l      <= '0;
         wdog        <= '0;
         REQ_READY   <= '0;
         RSP_VALID   <= '0;
         RSP_RDATA   <= '0;
         RSP_ERR     <= 1'b0;
         M_A_W_VALID <= 1'b0;
         M_W_VALID   <= 1'b0;
         M_B_READY   <= 1'b0;
         M_A_R_VALID <= 1'b0;
         M_R_READY   <= 1'b0;
      end else begin
         // Pulse outputs default low; each is raised for exactly one cycle.
         REQ_READY <= '0;
         RSP_VALID <= '0;
         M_B_READY <= 1'b0;
         M_R_READY <= 1'b0;

         if (in_wait && !hs && wd_hit) begin
            // Stalled slave: drop every channel and report an error to the owner.
            M_A_W_VALID <= 1'b0;
            M_W_VALID   <= 1'b0;
            M_A_R_VALID <= 1'b0;
            RSP_ERR     <= 1'b1;
            RSP_RDATA   <= '0;
            RSP_VALID   <= gnt_oh;
            wdog        <= '0;
            state       <= RSP;
         end else begin
            // Count stalled cycles; any state change restarts the count.
            if (in_wait && !hs) wdog <= wdog + 8'd1;
            else                wdog <= '0;

            case (state)
               IDLE: begin
                  if (|REQ_VALID) begin
                     REQ_READY <= win ? 2'b10 : 2'b01;
                     gnt       <= win;
                     last      <= win;
                     addr_l    <= win_addr;
                     data_l    <= win_data;
                     RSP_ERR   <= 1'b0;
                     RSP_RDATA <= '0;
                     if (win_write) begin
                        M_A_W_VALID <= 1'b1;
                        state       <= AW;
                     end else begin
                        M_A_R_VALID <= 1'b1;
                        state       <= AR;
                     end
                  end
               end
               AW: begin
                  if (hs) begin
                     M_A_W_VALID <= 1'b0;
                     M_W_VALID   <= 1'b1;
                     state       <= W;
                  end
               end
               W: begin
                  if (hs) begin
                     M_W_VALID <= 1'b0;
                     state     <= B;
                  end
               end
               B: begin
                  if (hs) begin
                     M_B_READY <= 1'b1;
                     RSP_ERR   <= |M_B_RESP;
                     RSP_RDATA <= '0;
                     RSP_VALID <= gnt_oh;
                     state     <= RSP;
                  end
               end
               AR: begin
                  if (hs) begin
                     M_A_R_VALID <= 1'b0;
                     state       <= R;
                  end
               end
               R: begin
                  if (hs) begin
                     M_R_READY <= 1'b1;
                     RSP_RDATA <= M_R_DATA;
                     RSP_ERR   <= 1'b0;
                     RSP_VALID <= gnt_oh;
                     state     <= RSP;
                  end
               end
               RSP:     state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter with a small behavioural memory slave.
module tb_axi4_mem_arbiter;

   localparam int TO = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  REQ_VALID, REQ_WRITE;
   logic [9:0]  REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic [1:0]  REQ_READY, RSP_VALID;
   logic [15:0] RSP_RDATA;
   logic        RSP_ERR;
   logic [4:0]  M_A_W_ADDR, M_A_R_ADDR;
   logic        M_A_W_VALID, M_W_VALID, M_B_READY, M_A_R_VALID, M_R_READY;
   logic [15:0] M_W_DATA;
   wire         M_A_W_READY, M_W_READY, M_B_VALID, M_A_R_READY, M_R_VALID;
   wire  [1:0]  M_B_RESP;
   wire  [15:0] M_R_DATA;

   // slave controls
   logic        aw_rdy, w_rdy, ar_rdy, b_manual, b_force;
   logic [1:0]  b_resp;
   // slave state
   logic        s_bv, s_rv;
   logic [1:0]  s_bresp;
   logic [15:0] s_rdata;
   logic [4:0]  s_awaddr, s_araddr;
   logic [15:0] mem [0:31];
   int          b_cnt, r_cnt;

   int checks = 0;
   int failures = 0;

   assign M_A_W_READY = aw_rdy;
   assign M_W_READY   = w_rdy;
   assign M_A_R_READY = ar_rdy;
   assign M_B_VALID   = s_bv | b_force;
   assign M_B_RESP    = b_force ? 2'b00 : s_bresp;
   assign M_R_VALID   = s_rv;
   assign M_R_DATA    = s_rdata;

   axi4_mem_arbiter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
      .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID),
      .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .M_A_W_ADDR(M_A_W_ADDR), .M_A_W_VALID(M_A_W_VALID), .M_A_W_READY(M_A_W_READY),
      .M_W_DATA(M_W_DATA), .M_W_VALID(M_W_VALID), .M_W_READY(M_W_READY),
      .M_B_VALID(M_B_VALID), .M_B_RESP(M_B_RESP), .M_B_READY(M_B_READY),
      .M_A_R_ADDR(M_A_R_ADDR), .M_A_R_VALID(M_A_R_VALID), .M_A_R_READY(M_A_R_READY),
      .M_R_DATA(M_R_DATA), .M_R_VALID(M_R_VALID), .M_R_READY(M_R_READY)
   );

   always #5 CLK = ~CLK;

   // Memory slave, evaluated mid-cycle; VALID is cleared once READY is seen.
   always @(negedge CLK) begin
      if (RESET) begin
         s_bv = 1'b0; s_rv = 1'b0; s_bresp = 2'b00; s_rdata = '0;
         b_cnt = 0; r_cnt = 0; s_awaddr = '0; s_araddr = '0;
         for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
      end else begin
         if (s_bv && M_B_READY) s_bv = 1'b0;
         if (s_rv && M_R_READY) s_rv = 1'b0;
         if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin s_bv = 1'b1; s_bresp = b_resp; end
         end
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin s_rv = 1'b1; s_rdata = mem[s_araddr]; end
         end
         if (M_A_W_VALID && M_A_W_READY) s_awaddr = M_A_W_ADDR;
         if (M_W_VALID && M_W_READY) begin
            mem[s_awaddr] = M_W_DATA;
            if (!b_manual) b_cnt = 1;
         end
         if (M_A_R_VALID && M_A_R_READY) begin s_araddr = M_A_R_ADDR; r_cnt = 1; end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request from requester r; returns grant, response and latency in cycles.
   task automatic txn(input int r, input logic wr, input logic [4:0] a, input logic [15:0] d,
                      output logic [1:0] gnt, output logic [1:0] rv, output logic [15:0] rd,
                      output logic e, output int lat, output int arv);
      int cs;
      cs = -1; gnt = '0; rv = '0; rd = 16'hDEAD; e = 1'bx; lat = -1; arv = 0;
      REQ_ADDR[5*r +: 5]   = a;
      REQ_WDATA[16*r +: 16] = d;
      REQ_WRITE[r] = wr;
      REQ_VALID[r] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (M_A_R_VALID) arv++;
         if (REQ_READY != 2'b00 && cs < 0) begin gnt = REQ_READY; cs = c; REQ_VALID = '0; end
         if (RSP_VALID != 2'b00) begin
            rv = RSP_VALID; rd = RSP_RDATA; e = RSP_ERR; lat = c - cs;
            break;
         end
      end
      REQ_VALID = '0;
   endtask

   logic [1:0]  g, rv;
   logic [15:0] rd;
   logic        e;
   int          lat, arv;
   int          c0, nrdy, frdy, frsp, nrsp, ng, nr, bad;
   logic        got_w;
   logic [1:0]  gseq [4];
   logic [1:0]  rseq [4];
   logic [15:0] dseq [4];

   initial begin
      RESET = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
      aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; b_resp = 2'b00; b_manual = 1'b0; b_force = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_ctrl", 32'({REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, M_A_W_VALID,
                               M_W_VALID, M_B_READY, M_A_R_VALID, M_R_READY}), 32'd0);
      check("reset_data", 32'({M_A_W_ADDR, M_A_R_ADDR, M_W_DATA}), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      // write 0xA5A5 to address 3, then read it back
      txn(0, 1'b1, 5'd3, 16'hA5A5, g, rv, rd, e, lat, arv);
      check("wr_grant", g, 2'b01);
      check("wr_rsp", rv, 2'b01);
      check("wr_err", e, 1'b0);
      check("wr_rdata", rd, 16'h0000);
      check("wr_latency", lat, 3);
      txn(0, 1'b0, 5'd3, 16'h0000, g, rv, rd, e, lat, arv);
      check("rd_rsp", rv, 2'b01);
      check("rd_data", rd, 16'hA5A5);
      check("rd_err", e, 1'b0);
      check("rd_latency", lat, 2);

      // error write response
      b_resp = 2'b10;
      txn(1, 1'b1, 5'd5, 16'h5A5A, g, rv, rd, e, lat, arv);
      check("berr_grant", g, 2'b10);
      check("berr_rsp", rv, 2'b10);
      check("berr_err", e, 1'b1);
      check("berr_rdata", rd, 16'h0000);
      b_resp = 2'b00;

      // read address never accepted -> watchdog abort
      ar_rdy = 1'b0;
      txn(1, 1'b0, 5'd4, 16'h0000, g, rv, rd, e, lat, arv);
      check("to_rsp", rv, 2'b10);
      check("to_err", e, 1'b1);
      check("to_rdata", rd, 16'h0000);
      check("to_arvalid_cycles", arv, TO);
      check("to_latency", lat, TO);
      ar_rdy = 1'b1;

      // slave holds B_VALID for 5 cycles: single READY pulse, response not before it
      b_manual = 1'b1;
      c0 = -1; nrdy = 0; frdy = -1; frsp = -1;
      REQ_ADDR[4:0] = 5'd6; REQ_WDATA[15:0] = 16'h0F0F; REQ_WRITE[0] = 1'b1; REQ_VALID[0] = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge CLK);
         if (REQ_READY[0] && c0 < 0) begin c0 = c; REQ_VALID = '0; end
         if (M_B_READY) begin nrdy++; if (frdy < 0) frdy = c; end
         if (RSP_VALID != 2'b00 && frsp < 0) frsp = c;
         if (c0 >= 0 && c == c0 + 3) b_force = 1'b1;
         if (c0 >= 0 && c == c0 + 8) b_force = 1'b0;
      end
      REQ_VALID = '0; b_force = 1'b0; b_manual = 1'b0;
      check("bhold_grant_seen", 32'(c0 >= 0), 32'd1);
      check("bhold_ready_pulses", nrdy, 1);
      check("bhold_ready_cycle", frdy - c0, 4);
      check("bhold_rsp_cycle", frsp - c0, 4);

      // reset while in W: channel drops at once, no response afterwards
      w_rdy = 1'b0; got_w = 1'b0; nrsp = 0;
      REQ_ADDR[4:0] = 5'd7; REQ_WDATA[15:0] = 16'h1234; REQ_WRITE[0] = 1'b1; REQ_VALID[0] = 1'b1;
      for (int c = 0; c < 10 && !got_w; c++) begin
         @(negedge CLK);
         if (REQ_READY[0]) REQ_VALID = '0;
         if (M_W_VALID) got_w = 1'b1;
      end
      check("rstw_reached_w", got_w, 1'b1);
      RESET = 1'b1; REQ_VALID = '0;
      #1;
      check("rstw_wvalid", M_W_VALID, 1'b0);
      check("rstw_outputs", 32'({REQ_READY, RSP_VALID, RSP_ERR, M_A_W_VALID, M_B_READY,
                                 M_A_R_VALID, M_R_READY}), 32'd0);
      repeat (2) begin @(negedge CLK); if (RSP_VALID != 2'b00) nrsp++; end
      RESET = 1'b0; w_rdy = 1'b1;
      repeat (3) begin @(negedge CLK); if (RSP_VALID != 2'b00) nrsp++; end
      check("rstw_no_rsp", nrsp, 0);

      // contention: both read continuously, requester 0 preferred after reset
      ng = 0; nr = 0; bad = 0;
      for (int k = 0; k < 4; k++) begin gseq[k] = '0; rseq[k] = '0; dseq[k] = '0; end
      REQ_ADDR = {5'd2, 5'd1}; REQ_WRITE = 2'b00; REQ_VALID = 2'b11;
      for (int c = 0; c < 60 && nr < 4; c++) begin
         @(negedge CLK);
         if (REQ_READY != 2'b00) begin
            if ($countones(REQ_READY) != 1) bad++;
            if (ng < 4) gseq[ng] = REQ_READY;
            ng++;
            if (ng == 4) REQ_VALID = '0;
         end
         if (RSP_VALID != 2'b00) begin
            if ($countones(RSP_VALID) != 1) bad++;
            if (nr < 4) begin rseq[nr] = RSP_VALID; dseq[nr] = RSP_RDATA; end
            nr++;
         end
      end
      REQ_VALID = '0;
      check("cont_grants", ng, 4);
      check("cont_onehot", bad, 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("cont_grant%0d", k), gseq[k], (k % 2) ? 2'b10 : 2'b01);
         check($sformatf("cont_rsp%0d", k), rseq[k], (k % 2) ? 2'b10 : 2'b01);
         check($sformatf("cont_data%0d", k), dseq[k], (k % 2) ? 16'h1002 : 16'h1001);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi4_mem_arbiter.md
AXI4_MEM_ARBITER -- requirements
Module: axi4_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of wait cycles per slave handshake before the transaction aborts (range 1..255).
REQ-002 SHALL have ports as follows:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  2  per-requester request; bit i belongs to requester i.
- REQ_WRITE  in  2  per-requester direction; 1 = write, 0 = read.
- REQ_ADDR  in  10  requester i address in bits [5i+4:5i].
- REQ_WDATA  in  32  requester i write data in bits [16i+15:16i].
- REQ_READY  out  2  one-cycle grant/accept pulse per requester.
- RSP_VALID  out  2  one-cycle completion pulse per requester.
- RSP_RDATA  out  16  read data, valid with RSP_VALID.
- RSP_ERR  out  1  error flag, valid with RSP_VALID.
- M_A_W_ADDR / M_A_W_VALID  out  5 / 1  write address channel to the memory slave.
- M_A_W_READY  in  1  write address accept.
- M_W_DATA / M_W_VALID  out  16 / 1  write data channel.
- M_W_READY  in  1  write data accept.
- M_B_VALID / M_B_RESP  in  1 / 2  write response.
- M_B_READY  out  1  write response accept.
- M_A_R_ADDR / M_A_R_VALID  out  5 / 1  read address channel.
- M_A_R_READY  in  1  read address accept.
- M_R_DATA / M_R_VALID  in  16 / 1  read data.
- M_R_READY  out  1  read data accept.

Function
REQ-003 SHALL share one slave between two requesters, with exactly one transaction in flight at any time.
REQ-004 SHALL implement states IDLE, AW, W, B, AR, R, RSP.
REQ-005 IDLE, arbitration:
- If exactly one REQ_VALID bit is set, that requester wins.
- If both are set, the requester not granted last wins (round-robin pointer LAST; LAST = 1 after reset, so requester 0 wins first).
REQ-006 On a win in IDLE: pulse REQ_READY[i] for one cycle; latch address, data, direction and grant index; update LAST; go to AW (write) or AR (read).
REQ-007 REQ_* inputs SHALL be ignored outside IDLE; requesters hold REQ_VALID until they see REQ_READY.
REQ-008 AW state:
- Drive M_A_W_VALID = 1 with the latched address.
- When M_A_W_READY is sampled 1: deassert M_A_W_VALID and go to W.
REQ-009 W state:
- Drive M_W_VALID = 1 with the latched data.
- When M_W_READY is sampled 1: deassert M_W_VALID and go to B.
REQ-010 B state:
- Keep M_B_READY = 0 until M_B_VALID is sampled 1.
- Then pulse M_B_READY for exactly one cycle.
- Set the error flag when M_B_RESP != 2'b00; go to RSP.
REQ-011 AR state: drive M_A_R_VALID = 1; when M_A_R_READY is sampled 1, deassert it and go to R.
REQ-012 R state:
- Keep M_R_READY = 0 until M_R_VALID is sampled 1.
- On that edge, capture M_R_DATA into RSP_RDATA and pulse M_R_READY for one cycle; go to RSP.
REQ-013 READY SHALL never be asserted before the slave's VALID has been observed; the slave clears VALID on the same edge it sees READY.
REQ-014 RSP state:
- Pulse RSP_VALID[grant] for one cycle with RSP_RDATA and RSP_ERR.
- RSP_RDATA SHALL be 0 for writes; return to IDLE.
REQ-015 Watchdog:
- An 8-bit counter clears on entry to AW, W, B, AR and R, and increments every cycle spent in those states.
- When it reaches TIMEOUT: drop all M_* VALID/READY, set RSP_ERR = 1, RSP_RDATA = 0, go to RSP.
REQ-016 Minimum latency from REQ_READY to RSP_VALID SHALL equal the sum of the slave wait cycles plus 1 per state; there SHALL be no idle bubble beyond IDLE's single arbitration cycle.
REQ-017 At most one bit of REQ_READY or RSP_VALID SHALL be high in any cycle.

Reset
REQ-018 While RESET = 1, all outputs SHALL be 0, state = IDLE, LAST = 1, watchdog = 0, latched registers = 0.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no RSP_VALID; after release, arbitration restarts with requester 0 preferred.

Verification
REQ-020 Write then read: requester 0 writes 0xA5A5 to address 3, then reads address 3 → RSP_VALID[0] with RSP_ERR = 0, then RSP_RDATA = 0xA5A5, RSP_ERR = 0.
REQ-021 Contention: both requesters hold REQ_VALID, for reads of addresses 1 and 2, → grant order 0,1,0,1; each RSP_VALID goes to the matching requester only.
REQ-022 Response handshake: slave holds M_B_VALID for 5 cycles → M_B_READY is a single pulse after M_B_VALID is seen, and no RSP_VALID occurs before it.
REQ-023 Timeout: TIMEOUT = 4 and M_A_R_READY tied 0 → M_A_R_VALID drops after 4 cycles; RSP_VALID with RSP_ERR = 1 and RSP_RDATA = 0.
REQ-024 Error response: M_B_RESP = 2'b10 → RSP_ERR = 1.
REQ-025 Reset in W state → M_W_VALID = 0 immediately; no response; the next request is served normally.
